// File: rtl/fingerprint_monitor.sv
// fingerprint_monitor
// Measures the frequency of a free-running ring oscillator by gating its
// counter for a fixed window of clk cycles and checking the counted delta
// against an inclusive [MIN_COUNT, MAX_COUNT] band. Each sample point is
// re-read until two consecutive register samples agree, because osc_count
// comes from another clock domain and may be mid-update.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   start        single-cycle measurement request, honoured only when idle
//   osc_count    32-bit oscillator counter value, asynchronous to clk
//   osc_enable   registered gate to the oscillator counter
//   busy         high from the first settle cycle through the done cycle
//   done         one-cycle pulse when pass/err_unstable/delta are valid
//   pass         held result: delta in band and samples were stable
//   err_unstable held result: a sample point never settled
//   delta        held measured count (end - base, modulo 2^32)
//   alarm        sticky tamper flag
//
// Configuration macro
//   FP_STICKY_ALARM_EN  when defined, alarm latches on any failing result and
//                       clears only on rst; when undefined alarm is tied low.

module fingerprint_monitor #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MIN_COUNT     = 4000,
    parameter int unsigned MAX_COUNT     = 8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] osc_count,
    output logic        osc_enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_unstable,
    output logic [31:0] delta,
    output logic        alarm
);

    // One counter serves both the settle and the gate phases.
    localparam int unsigned CNT_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE_PRE  = 3'd1,
        SAMPLE_BASE = 3'd2,
        GATE        = 3'd3,
        SETTLE_POST = 3'd4,
        SAMPLE_END  = 3'd5,
        COMPARE     = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       retry_r;
    logic             phase_r;
    logic [31:0]      samp_r;
    logic [31:0]      base_r;
    logic [31:0]      end_r;

    logic [31:0]      diff_s;
    logic             in_range_s;
    logic             samp_match_s;
    logic             last_retry_s;

    // Delta and band check are formed from registered samples only.
    always_comb begin
        diff_s       = end_r - base_r;
        in_range_s   = (diff_s >= 32'(MIN_COUNT)) && (diff_s <= 32'(MAX_COUNT));
        samp_match_s = (osc_count == samp_r);
        last_retry_s = (retry_r == 2'd3);
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            retry_r      <= 2'd0;
            phase_r      <= 1'b0;
            samp_r       <= 32'd0;
            base_r       <= 32'd0;
            end_r        <= 32'd0;
            osc_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_unstable <= 1'b0;
            delta        <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= SETTLE_PRE;
                        busy         <= 1'b1;
                        pass         <= 1'b0;
                        err_unstable <= 1'b0;
                        cnt_r        <= '0;
                        retry_r      <= 2'd0;
                    end
                end
                SETTLE_PRE, SETTLE_POST: begin
                    if (cnt_r == SET_LAST) begin
                        state_r <= (state_r == SETTLE_PRE) ? SAMPLE_BASE : SAMPLE_END;
                        cnt_r   <= '0;
                        phase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SAMPLE_BASE, SAMPLE_END: begin
                    if (!phase_r) begin
                        samp_r  <= osc_count;
                        phase_r <= 1'b1;
                    end else if (samp_match_s) begin
                        // Two agreeing reads: the counter is quiescent.
                        retry_r <= 2'd0;
                        phase_r <= 1'b0;
                        cnt_r   <= '0;
                        if (state_r == SAMPLE_BASE) begin
                            base_r     <= samp_r;
                            state_r    <= GATE;
                            osc_enable <= 1'b1;
                        end else begin
                            end_r   <= samp_r;
                            state_r <= COMPARE;
                        end
                    end else if (last_retry_s) begin
                        // Fourth disagreement: give up on this measurement.
                        state_r      <= DONE;
                        done         <= 1'b1;
                        err_unstable <= 1'b1;
                        pass         <= 1'b0;
                        delta        <= 32'd0;
                    end else begin
                        retry_r <= retry_r + 2'd1;
                        phase_r <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= (state_r == SAMPLE_BASE) ? SETTLE_PRE : SETTLE_POST;
                    end
                end
                GATE: begin
                    if (cnt_r == WIN_LAST) begin
                        osc_enable <= 1'b0;
                        state_r    <= SETTLE_POST;
                        cnt_r      <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                COMPARE: begin
                    delta        <= diff_s;
                    pass         <= in_range_s;
                    err_unstable <= 1'b0;
                    done         <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    osc_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP_STICKY_ALARM_EN
    logic fail_entry_s;

    // A failing result is one entering DONE without a pass.
    always_comb begin
        fail_entry_s = 1'b0;
        if (state_r == COMPARE) begin
            fail_entry_s = !in_range_s;
        end else if (((state_r == SAMPLE_BASE) || (state_r == SAMPLE_END)) && phase_r
                     && !samp_match_s && last_retry_s) begin
            fail_entry_s = 1'b1;
        end else begin
            fail_entry_s = 1'b0;
        end
    end

    // Sticky tamper flag; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (fail_entry_s) begin
            alarm <= 1'b1;
        end else begin
            alarm <= alarm;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_fingerprint_monitor.sv
// Directed bench for fingerprint_monitor with a scoreboard queue: each run
// pushes its expected result when start is driven and pops it on done.

module tb_fingerprint_monitor;

    localparam int unsigned W    = 1000;
    localparam int unsigned S    = 4;
    localparam int unsigned MINC = 4000;
    localparam int unsigned MAXC = 8000;

`ifdef FP_STICKY_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    typedef struct {
        logic        pass;
        logic        err;
        logic [31:0] delta;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] osc_count;
    logic        osc_enable;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err_unstable;
    logic [31:0] delta;
    logic        alarm;

    logic        load_en;
    logic [31:0] load_val;
    logic [31:0] step;
    logic        jitter;
    logic        exp_alarm;

    int cyc        = 0;
    int en_total   = 0;
    int done_total = 0;
    int total      = 0;
    int bad        = 0;
    exp_t sb_q[$];

    fingerprint_monitor #(
        .WINDOW_CYCLES(W),
        .SETTLE_CYCLES(S),
        .MIN_COUNT(MINC),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .osc_count(osc_count),
        .osc_enable(osc_enable),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_unstable(err_unstable),
        .delta(delta),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Oscillator model: preset, free-running jitter, or +step per gated cycle.
    always @(posedge clk) begin
        if (load_en) osc_count <= load_val;
        else if (jitter) osc_count <= osc_count + 32'd1;
        else if (osc_enable) osc_count <= osc_count + step;
    end

    // Cycle, gate-width and done-pulse tallies.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (osc_enable === 1'b1) en_total <= en_total + 1;
        if (done === 1'b1) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (osc_enable === lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] base, input logic [31:0] stp,
                       input bit jit, input int hold, input bit extra, input int linger);
        exp_t e;
        int   start_cyc;
        int   done_cyc;
        int   en0;
        int   d0;
        bit   ok;
        bit   got;
        @(negedge clk);
        load_en  = 1'b1;
        load_val = base;
        step     = stp;
        @(negedge clk);
        load_en = 1'b0;
        e.delta = stp * W;
        e.pass  = (e.delta >= MINC) && (e.delta <= MAXC);
        e.err   = 1'b0;
        e.lat   = 2 * S + W + 6;
        if (jit) begin
            e.delta = 32'd0;
            e.pass  = 1'b0;
            e.err   = 1'b1;
            e.lat   = -1;
        end
        sb_q.push_back(e);
        exp_alarm = exp_alarm | (ALARM_EN & !e.pass);
        en0       = en_total;
        d0        = done_total;
        start     = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < hold; i++) @(negedge clk);
        start = 1'b0;
        if (hold == 1) begin
            check({tag, "_clr_pass"}, {31'd0, pass}, 32'd0);
            check({tag, "_clr_err"}, {31'd0, err_unstable}, 32'd0);
        end
        if (extra) begin
            repeat (200) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (jit) begin
            wait_en(1'b1, ok);
            check({tag, "_gate_open"}, {31'd0, ok}, 32'd1);
            wait_en(1'b0, ok);
            check({tag, "_gate_close"}, {31'd0, ok}, 32'd1);
            jitter = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        done_cyc = cyc;
        jitter   = 1'b0;
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            e = sb_q.pop_front();
            check({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
            check({tag, "_err"}, {31'd0, err_unstable}, {31'd0, e.err});
            check({tag, "_delta"}, delta, e.delta);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
            if (e.lat >= 0) check({tag, "_latency"}, done_cyc - start_cyc, e.lat);
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            check({tag, "_gate_width"}, en_total - en0, W);
            check({tag, "_alarm"}, {31'd0, alarm}, {31'd0, exp_alarm});
            check({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, e.pass});
            repeat (linger) @(negedge clk);
            check({tag, "_done_count"}, done_total - d0, 32'd1);
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        bit ok;
        int d0;
        rst       = 1'b1;
        start     = 1'b1;
        load_en   = 1'b1;
        load_val  = 32'd0;
        step      = 32'd5;
        jitter    = 1'b0;
        exp_alarm = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        load_en = 1'b0;
        check("rst_osc_enable", {31'd0, osc_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {31'd0, err_unstable}, 32'd0);
        check("rst_delta", delta, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        @(negedge clk);
        check("rst_start_ignored", {31'd0, busy}, 32'd0);

        run("nominal",    32'd0,          32'd5, 1'b0, 1, 1'b0, 5);
        run("over",       32'd100,        32'd9, 1'b0, 1, 1'b0, 5);
        run("after_fail", 32'd0,          32'd5, 1'b0, 1, 1'b0, 5);
        run("min_edge",   32'd7,          32'd4, 1'b0, 1, 1'b0, 5);
        run("max_edge",   32'd0,          32'd8, 1'b0, 1, 1'b0, 5);
        run("below",      32'd0,          32'd3, 1'b0, 1, 1'b0, 5);
        run("wrap",       32'hFFFF_F000,  32'd5, 1'b0, 1, 1'b0, 5);
        run("unstable",   32'd0,          32'd5, 1'b1, 1, 1'b0, 5);

        // Abort a measurement during the gate window.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_en(1'b1, ok);
        check("abort_gate_open", {31'd0, ok}, 32'd1);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        d0  = done_total;
        @(negedge clk);
        rst       = 1'b0;
        exp_alarm = 1'b0;
        check("abort_osc_enable", {31'd0, osc_enable}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (1100) @(negedge clk);
        check("abort_no_done", done_total - d0, 32'd0);
        check("abort_alarm", {31'd0, alarm}, 32'd0);
        check("abort_enable_low", {31'd0, osc_enable}, 32'd0);

        run("post_rst",   32'd0,          32'd5, 1'b0, 1, 1'b0, 5);
        run("held",       32'd0,          32'd5, 1'b0, 3, 1'b1, 1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
